// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared defaults for the stream FIFO slice
//
// Holds the default geometry used by the top-level parameters. Widths derived
// from the parameters live as localparams inside each module, because they
// depend on per-instance values.
package stream_fifo_pkg;

  localparam int unsigned FIFO_DEFAULT_WIDTH = 32;
  localparam int unsigned FIFO_DEFAULT_DEPTH = 4;

endpackage : stream_fifo_pkg

// File: rtl/stream_fifo_regfile.sv
// rtl/stream_fifo_regfile.sv - DEPTH x BIT_WIDTH storage, sync write, comb read
//
// Ports:
//   clk    - write clock
//   wen    - write enable, sampled on rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
// Contents are deliberately not reset; the owner masks reads while empty.
module stream_fifo_regfile #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic [PTR_W-1:0]     waddr,
  input  logic [BIT_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]     raddr,
  output logic [BIT_WIDTH-1:0] rdata
);

  logic [BIT_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : stream_fifo_regfile

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FIFO buffering a crossbar output port
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous, active-low reset
//   recv_msg  - incoming word
//   recv_val  - incoming word valid
//   recv_rdy  - FIFO can accept a word (low while in reset or full)
//   send_msg  - head-of-queue word, zero while empty
//   send_val  - head word valid
//   send_rdy  - consumer accepts head word
//   count     - current occupancy, 0..DEPTH
// Both ready and valid come purely from registered state (plus the reset
// level for recv_rdy), so the block can sit after combinational-rdy sources.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = FIFO_DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BIT_WIDTH-1:0]   recv_msg,
  input  logic                   recv_val,
  output logic                   recv_rdy,
  output logic [BIT_WIDTH-1:0]   send_msg,
  output logic                   send_val,
  input  logic                   send_rdy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 empty, full;
  logic                 enq, deq;
  logic [BIT_WIDTH-1:0] head_word;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Full blocks enqueue even when a dequeue fires the same cycle: no
  // pass-through, so recv_rdy never depends on send_rdy.
  assign recv_rdy = !full && reset;
  assign send_val = !empty;

  assign enq = recv_val && recv_rdy;
  assign deq = send_val && send_rdy;

  stream_fifo_regfile #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .wen   (enq),
    .waddr (wr_ptr_q),
    .wdata (recv_msg),
    .raddr (rd_ptr_q),
    .rdata (head_word)
  );

  // Masking hides stale storage after reset or drain.
  assign send_msg = empty ? '0 : head_word;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so plain addition wraps modulo DEPTH.
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : stream_fifo

// File: doc/stream_fifo.md
# stream_fifo

Parameterised valid/ready FIFO that sits directly downstream of a crossbar output port. It absorbs back-pressure so a stalled consumer (FFT, serializer, Wishbone readback) does not immediately throttle the crossbar's selected input. It accepts one BIT_WIDTH word per cycle on its receive side and presents words in order on its send side. The storage read is combinational, so an enqueued word is presented one cycle after enqueue.

## Interface
- BIT_WIDTH, 32: width of each message word.
- DEPTH, 4: number of entries; power of two, ≥ 2.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- recv_msg  input  BIT_WIDTH  incoming word, from a crossbar send_msg slice.
- recv_val  input  1  incoming word valid.
- recv_rdy  output  1  FIFO can accept a word this cycle.
- send_msg  output  BIT_WIDTH  head-of-queue word.
- send_val  output  1  head word valid.
- send_rdy  input  1  consumer accepts head word this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Enqueue fires when recv_val && recv_rdy at a rising edge. Dequeue fires when send_val && send_rdy.
- State:
  - write pointer wr_ptr, $clog2(DEPTH) bits;
  - read pointer rd_ptr, $clog2(DEPTH) bits;
  - occupancy count, $clog2(DEPTH)+1 bits;
  - DEPTH × BIT_WIDTH storage array.
- Pointers increment modulo DEPTH, wrapping naturally from DEPTH-1 to 0.
- empty = (count == 0). full = (count == DEPTH).
- recv_rdy = !full && reset. recv_rdy is forced low while reset is asserted.
- send_val = !empty.
- send_msg = storage[rd_ptr] when !empty, else all zeros. The all-zeros value is required so the bench can check it deterministically.
- On enqueue: storage[wr_ptr] ← recv_msg, and wr_ptr increments.
- On dequeue: rd_ptr increments.
- count update:
  - enqueue only: +1;
  - dequeue only: −1;
  - both: unchanged;
  - neither: unchanged.
- Boundary conditions:
  - Full: recv_rdy = 0, so no enqueue occurs even if a dequeue fires in the same cycle. There is no full pass-through; recv_rdy returns to 1 the cycle after the dequeue.
  - Empty: send_val = 0, so a dequeue is impossible. There is no empty bypass; a word enqueued into an empty FIFO appears on send_msg the next cycle.
  - Simultaneous enqueue and dequeue at 0 < count < DEPTH: both pointers advance, count holds, ordering is preserved.
  - recv_val low, or send_rdy low: the corresponding side holds state; messages are not sampled.
- Reset, including mid-operation:
  - wr_ptr, rd_ptr and count are cleared immediately (asynchronously) and all queued words are discarded.
  - Storage contents are not reset and are unobservable, because send_msg is masked to zero while empty.
- Reset values of outputs: recv_rdy = 0, send_val = 0, send_msg = 0, count = 0.
- After reset deasserts, recv_rdy = 1 in that same cycle (combinational on the reset level).

## Timing
- Minimum latency recv → send: 1 cycle. A word enqueued at edge N has send_val = 1 after edge N.
- Throughput: one word per cycle sustained on both sides whenever 0 < count < DEPTH.
- recv_rdy depends only on registered count and the reset level. send_val and send_msg depend only on registered state. No combinational path from recv_val to send_val, or from send_rdy to recv_rdy.
- No ready-to-valid dependency on either side, so the block is safe to chain after crossbar outputs whose rdy is combinational.

## Structure
- No shared package required. Derived widths are localparams: PTR_W = $clog2(DEPTH), CNT_W = PTR_W + 1.
- One sub-module is natural: stream_fifo_regfile, a DEPTH × BIT_WIDTH array with one synchronous write port (wen, waddr, wdata) and one combinational read port (raddr → rdata). It has no reset.
- Top level holds the pointers, the count, the handshake logic and the empty masking.

## Test plan
- Reset behaviour: hold reset = 0 with recv_val = 1 → recv_rdy = 0, send_val = 0, count = 0, send_msg = 0. Release reset → recv_rdy = 1 the same cycle.
- Single word (DEPTH = 4): enqueue 0xDEADBEEF with send_rdy = 0 → the next cycle send_val = 1, send_msg = 0xDEADBEEF, count = 1. Raise send_rdy → the following cycle send_val = 0, count = 0.
- Fill and drain: enqueue 0x1, 0x2, 0x3, 0x4 with send_rdy = 0 → count = 4, recv_rdy = 0, and a fifth word 0x5 is not accepted. Drain → outputs 1, 2, 3, 4 in order, and recv_rdy = 1 the cycle after the first dequeue.
- Wrap-around with simultaneous events: stream 12 words (0x10..0x1B) with recv_val = 1 and send_rdy toggling 1/0 → output order is exactly 0x10..0x1B, count never exceeds 4, and during cycles where both enqueue and dequeue fire, count is unchanged.
- Reset mid-operation: with count = 3, assert reset between edges → count = 0, send_val = 0 and send_msg = 0 immediately. After release, enqueue 0xA5 → the next head word is 0xA5; no stale data appears.
